// File: rtl/ldpc_phase_scheduler.sv
// ldpc_phase_scheduler: CNU/VNU phase sequencer with iteration count and ping-pong frame banks.
// Define LDPC_EARLY_TERM_EN to add syndrome_ok, which ends a decode early after a VNU phase.
module ldpc_phase_scheduler #(
    parameter int L          = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNU_DELAY  = 5,
    parameter int VNU_DELAY  = 3,
    parameter int MAX_ITER   = 18,
    parameter int ITR_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic                  enable_pe,
    output logic                  vnu_en,
    output logic                  ag_reset,
    output logic                  extended,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  f_id,
    output logic [ITR_WIDTH-1:0]  itr,
    output logic                  busy
`ifdef LDPC_EARLY_TERM_EN
    ,
    input  logic                  syndrome_ok
`endif
);
    localparam int MAXD = CNU_DELAY > VNU_DELAY ? CNU_DELAY : VNU_DELAY;
    localparam int CW   = $clog2(MAXD + 2);

    typedef enum logic [2:0] {IDLE, CNU_RUN, CNU_DRAIN, SWITCH, VNU_RUN, VNU_DRAIN, DONE} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         cnt_q;
    logic [ITR_WIDTH-1:0]  itr_q;
    logic                  f_id_q, vnu_en_q, enable_pe_q, ag_reset_q, extended_q;
    logic                  dec_valid_q, out_full_q, load_full_q;
    logic [ITR_WIDTH-1:0]  itr_d;
    logic                  handshake, last_addr, early, stop;

`ifdef LDPC_EARLY_TERM_EN
    assign early = syndrome_ok;
`else
    assign early = 1'b0;
`endif

    assign handshake = dec_valid_q && dec_ready;
    assign last_addr = addr_q == ADDR_WIDTH'(L - 1);
    assign itr_d     = itr_q + ITR_WIDTH'(1);
    assign stop      = itr_d == ITR_WIDTH'(MAX_ITER) || early;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            itr_q       <= '0;
            f_id_q      <= 1'b0;
            vnu_en_q    <= 1'b0;
            enable_pe_q <= 1'b0;
            ag_reset_q  <= 1'b1;
            extended_q  <= 1'b0;
            dec_valid_q <= 1'b0;
            out_full_q  <= 1'b0;
            load_full_q <= 1'b0;
        end else begin
            ag_reset_q <= 1'b0;
            if (frame_valid && !load_full_q) load_full_q <= 1'b1;
            if (handshake) begin
                out_full_q  <= 1'b0;
                dec_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: if (load_full_q && (!out_full_q || handshake)) begin
                    state_q     <= CNU_RUN;
                    f_id_q      <= ~f_id_q;
                    load_full_q <= 1'b0;
                    itr_q       <= '0;
                    addr_q      <= '0;
                    enable_pe_q <= 1'b1;
                    vnu_en_q    <= 1'b0;
                    ag_reset_q  <= 1'b1;
                end
                CNU_RUN, VNU_RUN: if (last_addr) begin
                    state_q    <= state_q == CNU_RUN ? CNU_DRAIN : VNU_DRAIN;
                    extended_q <= 1'b1;
                    cnt_q      <= state_q == CNU_RUN ? CW'(CNU_DELAY - 1) : CW'(VNU_DELAY - 1);
                end else begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                end
                CNU_DRAIN, VNU_DRAIN: if (cnt_q == '0) begin
                    state_q    <= SWITCH;
                    extended_q <= 1'b0;
                    ag_reset_q <= 1'b1;
                    addr_q     <= '0;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
                SWITCH: begin
                    vnu_en_q <= ~vnu_en_q;
                    if (!vnu_en_q) begin
                        state_q <= VNU_RUN;
                    end else begin
                        itr_q   <= itr_d;
                        state_q <= stop ? DONE : CNU_RUN;
                        if (stop) begin
                            out_full_q  <= 1'b1;
                            dec_valid_q <= 1'b1;
                            enable_pe_q <= 1'b0;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign frame_ready = !load_full_q;
    assign dec_valid   = dec_valid_q;
    assign enable_pe   = enable_pe_q;
    assign vnu_en      = vnu_en_q;
    assign ag_reset    = ag_reset_q;
    assign extended    = extended_q;
    assign addr        = addr_q;
    assign f_id        = f_id_q;
    assign itr         = itr_q;
    assign busy        = state_q != IDLE;
endmodule
